csdiv_seq: RTL and testbench
============================

# csdiv_seq

Sequential restoring divider: the inverse operation of the carry-save multiplier. It divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor and returns a 2·WIDTH-bit quotient and a WIDTH-bit remainder. It resolves one quotient bit per clock, so a full product from the multiplier goes back to its factors in 2·WIDTH cycles. It sits beside the multiplier in the arithmetic unit and uses a start/done handshake.

## Interface
- WIDTH, 8, divisor/remainder width; dividend and quotient are 2·WIDTH bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- dividend  in  2·WIDTH  numerator, captured on the accepting edge
- divisor  in  WIDTH  denominator, captured on the accepting edge
- quotient  out  2·WIDTH  result, valid while done=1
- remainder  out  WIDTH  result, valid while done=1
- busy  out  1  division in progress
- done  out  1  result valid; held until the next accepted start
- div_by_zero  out  1  last accepted divisor was 0; valid while done=1

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with quotient=0, remainder=0, busy=0, done=0, div_by_zero=0. Internal counters and working registers also clear to 0.
- Accept: start=1 at a rising edge in IDLE or DONE. Operands are latched, and done and div_by_zero clear.
  - divisor≠0: go to RUN, busy=1, iteration counter=2·WIDTH.
  - divisor=0: go directly to DONE on the next edge (see Timing).
- start=1 in RUN is ignored. Operand changes after the accept edge have no effect.
- RUN datapath, one iteration per edge, for 2·WIDTH iterations, MSB first:
  - Partial remainder P is WIDTH+1 bits.
  - P' = {P[WIDTH-1:0], dividend_shift MSB}; shift the dividend register left.
  - If P' ≥ divisor: P = P' − divisor and shift 1 into the quotient LSB.
  - Otherwise: P = P' and shift 0 into the quotient LSB.
- End of RUN: after the last iteration, go to DONE with busy=0, done=1, quotient = final quotient register, remainder = P[WIDTH-1:0].
- Divide by zero: quotient = all ones (2·WIDTH bits), remainder = dividend[WIDTH-1:0], div_by_zero=1, done=1.
- Outputs: quotient and remainder are registered. They keep the previous result until the new result is written on the DONE-entry edge; they are undefined for consumption while done=0.
- Invariant: for divisor≠0, dividend = quotient·divisor + remainder and remainder < divisor. No overflow is possible because quotient is 2·WIDTH bits.

## Timing
- Accept edge E0 with a nonzero divisor:
  - busy=1 after E0.
  - Iterations on E1…E(2·WIDTH).
  - done=1 and busy=0 after E(2·WIDTH).
  - Latency is 2·WIDTH cycles (16 for WIDTH=8).
- Accept edge E0 with divisor=0: busy=1 after E0; done=1, div_by_zero=1 and busy=0 after E1.
- Back-to-back: start held high in DONE is accepted on the first DONE edge. done drops after that edge, so throughput is one result per 2·WIDTH+1 cycles.
- start held high continuously: a new division restarts every time the block reaches DONE.
- rst asserted at any time, including mid-RUN: outputs and state clear immediately, without waiting for clk. The in-flight division is discarded. The first edge after rst deasserts may accept start.

## Test plan
- Reset: assert rst mid-RUN → busy, done, quotient and remainder read 0 immediately; block returns to IDLE.
- 65025 / 255, then 15000 / 100 → quotient 255 remainder 0, then quotient 150 remainder 0. done rises exactly 16 cycles after each accept; busy is high for exactly 16 cycles.
- 2674 / 11, then 25652 / 212 → quotient 243 remainder 1, then quotient 121 remainder 0. A different start pulse and operand change mid-RUN is ignored.
- 65535 / 1, then 255 / 255, then 100 / 200 → quotient 65535 remainder 0; quotient 1 remainder 0; quotient 0 remainder 100.
- 1000 / 0 → one cycle after accept: done=1, div_by_zero=1, quotient 65535, remainder 232 (0x3E8 low byte). A following 1000 / 7 gives div_by_zero=0, quotient 142, remainder 6.
- Random sweep, 1000 operand pairs with divisor≠0, back-to-back starts → invariant holds for every result.

Source files
------------

// File: rtl/csdiv_seq_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The requester drives operands and start; the divider returns the results and status.
interface csdiv_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   busy;
    logic                   done;
    logic                   div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/csdiv_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, MSB first, with a start/done handshake.
module csdiv_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    csdiv_seq_if.slave  bus
);
    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [QW-1:0]    dividend_shift;
    logic [QW-1:0]    quot_work;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH:0]   part_rem;
    logic [CW-1:0]    iter_count;
    logic             zero_div;

    logic [QW-1:0]    quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic             accept;
    logic             finish;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_next;
    logic             fits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor still spends one cycle in RUN so busy is visible before done.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (zero_div || iter_count == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        p_shift = {part_rem[WIDTH-1:0], dividend_shift[QW-1]};
        fits    = (p_shift >= {1'b0, divisor_reg});
        p_next  = fits ? (p_shift - {1'b0, divisor_reg}) : p_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_shift  <= '0;
            quot_work       <= '0;
            divisor_reg     <= '0;
            part_rem        <= '0;
            iter_count      <= '0;
            zero_div        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else if (accept) begin
            dividend_shift  <= bus.dividend;
            divisor_reg     <= bus.divisor;
            quot_work       <= '0;
            part_rem        <= '0;
            iter_count      <= CW'(QW);
            zero_div        <= (bus.divisor == '0);
            div_by_zero_reg <= 1'b0;
        end else if (state == RUN) begin
            if (!zero_div) begin
                dividend_shift <= dividend_shift << 1;
                part_rem       <= p_next;
                quot_work      <= {quot_work[QW-2:0], fits};
                iter_count     <= iter_count - CW'(1);
            end
            // The untouched dividend register still holds the original low half here.
            if (finish) begin
                if (zero_div) begin
                    quotient_reg    <= '1;
                    remainder_reg   <= dividend_shift[WIDTH-1:0];
                    div_by_zero_reg <= 1'b1;
                end else begin
                    quotient_reg    <= {quot_work[QW-2:0], fits};
                    remainder_reg   <= p_next[WIDTH-1:0];
                    div_by_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_csdiv_seq.sv
// Self-checking bench for csdiv_seq: scoreboard of expected quotient/remainder
// pairs, pushed at each start and popped when done rises.
module tb_csdiv_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    csdiv_seq_if #(.WIDTH(8)) bus ();

    csdiv_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one accept at the next rising edge and records what it must produce.
    task automatic start_div(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (b == 8'd0) begin
            e.q  = 16'hFFFF;
            e.r  = a[7:0];
            e.dz = 1'b1;
        end else begin
            e.q  = a / {8'd0, b};
            e.r  = 8'(a % {8'd0, b});
            e.dz = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts rising edges until done is seen; n = -1 when the budget runs out.
    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) return;
            if (bus.busy) bn++;
            n++;
        end
        n = -1;
    endtask

    task automatic test_reset();
        int   n, bn;
        exp_t e;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
            bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dz=%b required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        start_div(16'd100, 8'd7);
        wait_done(n, bn);
        e = sb.pop_front();
        total++;
        if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            bad++;
            $display("[TB] FAIL pre_reset_div: got q=%0d r=%0d required q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        start_div(16'd65025, 8'd255);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
            bus.remainder !== 8'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b q=%0d r=%0d required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b required 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_latency();
        int   n, bn;
        exp_t e;
        logic [15:0] a_tab [2];
        logic [7:0]  b_tab [2];
        a_tab = '{16'd65025, 16'd15000};
        b_tab = '{8'd255, 8'd100};
        for (int i = 0; i < 2; i++) begin
            start_div(a_tab[i], b_tab[i]);
            wait_done(n, bn);
            e = sb.pop_front();
            total++;
            if (n !== 16 || bn !== 16) begin
                bad++;
                $display("[TB] FAIL latency_%0d: got cycles=%0d busy=%0d required 16 16", i, n, bn);
            end
            total++;
            if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== 1'b0) begin
                bad++;
                $display("[TB] FAIL latency_result_%0d: got q=%0d r=%0d dz=%b required q=%0d r=%0d dz=0",
                         i, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r);
            end
        end
    endtask

    task automatic test_midrun_ignore();
        int   n, bn;
        exp_t e;
        start_div(16'd2674, 8'd11);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd25652;
        bus.divisor  = 8'd212;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bn);
        e = sb.pop_front();
        total++;
        if (n !== 11) begin
            bad++;
            $display("[TB] FAIL midrun_timing: got remaining=%0d required 11", n);
        end
        total++;
        if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            bad++;
            $display("[TB] FAIL midrun_result: got q=%0d r=%0d required q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        start_div(16'd25652, 8'd212);
        wait_done(n, bn);
        e = sb.pop_front();
        total++;
        if (n !== 16 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            bad++;
            $display("[TB] FAIL second_result: got n=%0d q=%0d r=%0d required n=16 q=%0d r=%0d",
                     n, bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    task automatic test_boundaries();
        int   n, bn;
        exp_t e;
        logic [15:0] a_tab [3];
        logic [7:0]  b_tab [3];
        a_tab = '{16'd65535, 16'd255, 16'd100};
        b_tab = '{8'd1, 8'd255, 8'd200};
        for (int i = 0; i < 3; i++) begin
            start_div(a_tab[i], b_tab[i]);
            wait_done(n, bn);
            e = sb.pop_front();
            total++;
            if (n !== 16 || bus.quotient !== e.q || bus.remainder !== e.r) begin
                bad++;
                $display("[TB] FAIL boundary_%0d: got n=%0d q=%0d r=%0d required n=16 q=%0d r=%0d",
                         i, n, bus.quotient, bus.remainder, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   n, bn;
        exp_t e;
        start_div(16'd1000, 8'd0);
        wait_done(n, bn);
        e = sb.pop_front();
        total++;
        if (n !== 1 || bn !== 1) begin
            bad++;
            $display("[TB] FAIL dz_timing: got cycles=%0d busy=%0d required 1 1", n, bn);
        end
        total++;
        if (bus.div_by_zero !== e.dz || bus.quotient !== e.q || bus.remainder !== e.r) begin
            bad++;
            $display("[TB] FAIL dz_result: got dz=%b q=%0d r=%0d required dz=%b q=%0d r=%0d",
                     bus.div_by_zero, bus.quotient, bus.remainder, e.dz, e.q, e.r);
        end
        start_div(16'd1000, 8'd7);
        @(negedge clk);
        total++;
        if (bus.div_by_zero !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dz_clear: got dz=%b done=%b required 0 0", bus.div_by_zero, bus.done);
        end
        wait_done(n, bn);
        e = sb.pop_front();
        total++;
        if (bus.div_by_zero !== 1'b0 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            bad++;
            $display("[TB] FAIL after_dz: got dz=%b q=%0d r=%0d required dz=0 q=%0d r=%0d",
                     bus.div_by_zero, bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    // start stays high throughout, so every DONE edge launches the next division.
    task automatic test_back_to_back();
        int          n, bn;
        exp_t        e;
        logic [15:0] a;
        logic [7:0]  b;
        logic [31:0] recon;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            bus.start    = 1'b1;
            bus.dividend = a;
            bus.divisor  = b;
            e.q  = a / {8'd0, b};
            e.r  = 8'(a % {8'd0, b});
            e.dz = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
            wait_done(n, bn);
            total++;
            if (n !== 16) begin
                bad++;
                $display("[TB] FAIL b2b_latency_%0d: got %0d required 16", i, n);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL b2b_scoreboard_%0d: got empty queue required one entry", i);
            end else begin
                e = sb.pop_front();
                recon = 32'(bus.quotient) * 32'(b) + 32'(bus.remainder);
                if (bus.quotient !== e.q || bus.remainder !== e.r || recon !== 32'(a) ||
                    bus.remainder >= b) begin
                    bad++;
                    $display("[TB] FAIL b2b_result_%0d: %0d/%0d got q=%0d r=%0d required q=%0d r=%0d",
                             i, a, b, bus.quotient, bus.remainder, e.q, e.r);
                end
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_midrun_ignore();
        test_boundaries();
        test_div_by_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
